alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// ALU command sequencer: collects operand A, operand B and an opcode from a
// valid/ready stream, runs one ALU cycle, then holds the result until consumed.
module alu_sequencer #(
    parameter int unsigned bits = 8  // datapath width, must be >= 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [bits-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            abort,
    output logic [bits-1:0] alu_a,
    output logic [bits-1:0] alu_b,
    output logic [3:0]      alu_sel,
    input  logic [bits-1:0] alu_c,
    input  logic            alu_zero,
    output logic [bits-1:0] res_data,
    output logic            res_zero,
    output logic            res_illegal,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [7:0]      op_count,
    output logic            busy
);

    typedef enum logic [2:0] {
        StGetA,
        StGetB,
        StGetOp,
        StExec,
        StResult
    } state_e;

    state_e          state_q, state_d;
    logic [bits-1:0] alu_a_q, alu_a_d;
    logic [bits-1:0] alu_b_q, alu_b_d;
    logic [3:0]      alu_sel_q, alu_sel_d;
    logic [bits-1:0] res_data_q, res_data_d;
    logic            res_zero_q, res_zero_d;
    logic            res_illegal_q, res_illegal_d;
    logic [7:0]      op_count_q, op_count_d;
    logic            xfer;
    logic            sel_legal;

    // Opcodes the ALU actually implements; anything else is flagged but still run.
    always_comb begin
        sel_legal = 1'b0;
        unique case (alu_sel_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: sel_legal = 1'b1;
            default:                                     sel_legal = 1'b0;
        endcase
    end

    // Handshake and status decoded purely from state, never from in_valid.
    always_comb begin
        in_ready = (state_q == StGetA) || (state_q == StGetB) || (state_q == StGetOp);
        busy     = (state_q != StGetA);
        res_valid = (state_q == StResult);
        xfer     = in_valid && in_ready && !abort;
    end

    // Next-state and register updates; abort overrides every other action.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        res_data_d    = res_data_q;
        res_zero_d    = res_zero_q;
        res_illegal_d = res_illegal_q;
        op_count_d    = op_count_q;

        if (abort) begin
            state_d   = StGetA;
            alu_a_d   = '0;
            alu_b_d   = '0;
            alu_sel_d = '0;
        end else begin
            unique case (state_q)
                StGetA: begin
                    if (xfer) begin
                        alu_a_d = in_data;
                        state_d = StGetB;
                    end
                end
                StGetB: begin
                    if (xfer) begin
                        alu_b_d = in_data;
                        state_d = StGetOp;
                    end
                end
                StGetOp: begin
                    if (xfer) begin
                        alu_sel_d = in_data[3:0];
                        state_d   = StExec;
                    end
                end
                StExec: begin
                    res_data_d    = alu_c;
                    res_zero_d    = alu_zero;
                    res_illegal_d = !sel_legal;
                    state_d       = StResult;
                end
                StResult: begin
                    if (res_ready) begin
                        op_count_d = op_count_q + 8'd1;
                        state_d    = StGetA;
                    end
                end
                default: state_d = StGetA;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StGetA;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= '0;
            res_data_q    <= '0;
            res_zero_q    <= 1'b0;
            res_illegal_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            res_data_q    <= res_data_d;
            res_zero_q    <= res_zero_d;
            res_illegal_q <= res_illegal_d;
            op_count_q    <= op_count_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign res_data    = res_data_q;
    assign res_zero    = res_zero_q;
    assign res_illegal = res_illegal_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU attached.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_c;
    logic       alu_zero;
    logic [7:0] res_data;
    logic       res_zero;
    logic       res_illegal;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] op_count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.bits(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .abort      (abort),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_c      (alu_c),
        .alu_zero   (alu_zero),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_illegal(res_illegal),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .op_count   (op_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: AND, OR, ADD, SUB, SLT; unused codes fall back to XOR.
    always_comb begin
        case (alu_sel)
            4'h0:    alu_c = alu_a & alu_b;
            4'h1:    alu_c = alu_a | alu_b;
            4'h2:    alu_c = alu_a + alu_b;
            4'h6:    alu_c = alu_a - alu_b;
            4'h7:    alu_c = {7'd0, (alu_a < alu_b)};
            default: alu_c = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_c == 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Feed A, B, opcode and let EXEC close; leaves the DUT in RESULT.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send(a);
        send(b);
        send(op);
        tick();
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b0;
        #2;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        #10;
        rst_n = 1'b1;

        // 5 + 3: latency and first completion
        send(8'h05);
        chk("a_loaded", alu_a, 8'h05);
        chk("busy_get_b", busy, 1);
        send(8'h03);
        chk("b_loaded", alu_b, 8'h03);
        send(8'h02);
        chk("sel_loaded", alu_sel, 4'h2);
        chk("exec_no_valid", res_valid, 0);
        chk("exec_in_ready", in_ready, 0);
        tick();
        chk("add_valid", res_valid, 1);
        chk("add_data", res_data, 8'h08);
        chk("add_zero", res_zero, 0);
        chk("add_illegal", res_illegal, 0);
        chk("add_count_before", op_count, 0);
        accept();
        chk("add_count_after", op_count, 1);
        chk("add_done_valid", res_valid, 0);
        chk("add_done_busy", busy, 0);
        chk("add_retained", res_data, 8'h08);

        // Subtraction to zero and non-zero
        run_op(8'h07, 8'h07, 8'h06);
        chk("sub0_data", res_data, 8'h00);
        chk("sub0_zero", res_zero, 1);
        accept();
        run_op(8'h07, 8'h02, 8'h06);
        chk("sub5_data", res_data, 8'h05);
        chk("sub5_zero", res_zero, 0);
        accept();
        chk("count_3", op_count, 3);

        // Illegal opcode still completes and counts
        run_op(8'h0F, 8'hF0, 8'h03);
        chk("ill_flag", res_illegal, 1);
        chk("ill_data", res_data, 8'hFF);
        accept();
        chk("ill_count", op_count, 4);

        // Upper opcode bits are ignored
        run_op(8'h01, 8'h01, 8'h12);
        chk("upper_sel", alu_sel, 4'h2);
        chk("upper_data", res_data, 8'h02);
        chk("upper_legal", res_illegal, 0);
        accept();
        chk("upper_count", op_count, 5);

        // Backpressure in RESULT with input traffic pending
        run_op(8'h10, 8'h20, 8'h00);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 8'h00);
            chk("hold_zero", res_zero, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_alu_a", alu_a, 8'h10);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        in_valid  = 1'b0;
        chk("hold_release_busy", busy, 0);
        chk("hold_release_count", op_count, 6);

        // Abort in GET_B
        send(8'h55);
        chk("abort_pre_a", alu_a, 8'h55);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_b_busy", busy, 0);
        chk("abort_b_alu_a", alu_a, 0);
        chk("abort_b_count", op_count, 6);

        // Abort in GET_A wins over a valid transfer
        in_data  = 8'h77;
        in_valid = 1'b1;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_a_alu_a", alu_a, 0);
        chk("abort_a_busy", busy, 0);

        // Abort together with res_ready in RESULT
        run_op(8'h01, 8'h02, 8'h02);
        chk("abort_r_data", res_data, 8'h03);
        res_ready = 1'b1;
        abort     = 1'b1;
        tick();
        res_ready = 1'b0;
        abort     = 1'b0;
        chk("abort_r_valid", res_valid, 0);
        chk("abort_r_count", op_count, 6);
        chk("abort_r_alu_b", alu_b, 0);
        chk("abort_r_alu_sel", alu_sel, 0);
        chk("abort_r_retained", res_data, 8'h03);

        // Wrap op_count from 6 through 255 to 0
        for (int i = 0; i < 250; i++) begin
            run_op(i[7:0], 8'h01, 8'h02);
            accept();
        end
        chk("wrap_count", op_count, 0);

        // Asynchronous reset in the middle of EXEC
        send(8'h09);
        send(8'h04);
        send(8'h01);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_sel", alu_sel, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_zero", res_zero, 0);
        chk("mid_rst_illegal", res_illegal, 0);
        chk("mid_rst_count", op_count, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        #1;
        rst_n = 1'b1;

        // First transfer after reset is operand A
        run_op(8'h03, 8'h04, 8'h02);
        chk("post_rst_a", alu_a, 8'h03);
        chk("post_rst_data", res_data, 8'h07);
        accept();
        chk("post_rst_count", op_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
